conv_result_packer_dma64: RTL and testbench
===========================================

CONV_RESULT_PACKER_DMA64 -- requirements
Module: conv_result_packer_dma64

Interface
REQ-001 Parameter: MAP_WORDS, 4096, results per map; SHALL be even and at least 2.
REQ-002 Parameter: FIFO_DEPTH, 8, packed-beat FIFO entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter: MAP0_BASE, 32'h0000_0000, DMA index for map 0.
REQ-004 Parameter: MAP1_BASE, 32'h0000_4000, DMA index for map 1.
REQ-005 clk  in  1  clock; all state SHALL be updated on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin packing one map.
REQ-008 map_sel  in  1  map to pack (0/1); sampled when start is accepted.
REQ-009 res_wr  in  1  result strobe from the conv core; the core applies no backpressure.
REQ-010 res_data  in  20  result value.
REQ-011 res_sel  in  3  result destination select.
REQ-012 dma_write_ctrl_ready  in  1  write command accept.
REQ-013 dma_write_ctrl_valid  out  1  write command valid.
REQ-014 dma_write_ctrl_data_index  out  32  command index.
REQ-015 dma_write_ctrl_data_length  out  32  command length in bytes.
REQ-016 dma_write_ctrl_data_size  out  3  beat size code.
REQ-017 dma_write_chnl_ready  in  1  write data accept.
REQ-018 dma_write_chnl_valid  out  1  write data valid.
REQ-019 dma_write_chnl_data  out  64  packed beat.
REQ-020 done  out  1  one-cycle pulse when the map is complete.
REQ-021 overflow  out  1  sticky flag: a beat was dropped.
REQ-022 debug  out  32  {27'd0, overflow, fifo_empty, state[2:0]}.

Function
REQ-023 States SHALL be IDLE, CMD, DATA and FLUSH, encoded 0, 1, 2 and 3 respectively.
REQ-024 In IDLE, start SHALL:
  - latch map_sel;
  - set dma_write_ctrl_valid = 1, index = map_sel ? MAP1_BASE : MAP0_BASE, length = MAP_WORDS*4, size = 3'd3;
  - clear the result counter, the beat counter, the half flag and the FIFO;
  - go to CMD.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 In CMD, dma_write_ctrl_valid and all command fields SHALL hold until dma_write_ctrl_ready = 1; the cycle after the handshake, valid = 0 and the state is DATA.
REQ-027 A result SHALL be accepted only when all hold:
  - state is CMD or DATA;
  - res_wr = 1;
  - res_sel == 3'd1 + map_sel;
  - result counter < MAP_WORDS.
REQ-028 Non-matching res_sel, or results beyond MAP_WORDS, SHALL be discarded silently.
REQ-029 Packing:
  - even-indexed result (half = 0) goes to hold[19:0] and sets half = 1;
  - odd-indexed result forms beat {12'd0, res_data, 12'd0, hold[19:0]}, i.e. odd result in [51:32], even result in [19:0], all other bits 0;
  - the beat is pushed into the FIFO and half is cleared.
REQ-030 A completed beat SHALL be visible on dma_write_chnl_data / dma_write_chnl_valid in the cycle after the odd result's res_wr cycle if the FIFO was empty.
REQ-031 dma_write_chnl_valid SHALL be 1 exactly when the FIFO is non-empty and state is DATA or FLUSH.
REQ-032 dma_write_chnl_data SHALL be the head entry.
REQ-033 Data SHALL be stable while valid = 1 and ready = 0.
REQ-034 Pop SHALL occur on valid && ready and increment the beat counter.
REQ-035 Push and pop in the same cycle SHALL both take effect; a push into a full FIFO with a simultaneous pop SHALL succeed.
REQ-036 A push into a full FIFO without a simultaneous pop SHALL drop the beat and set overflow = 1; the beat counter target is unchanged.
REQ-037 overflow SHALL clear only on reset or on an accepted start.
REQ-038 When the result counter reaches MAP_WORDS, the state SHALL go to FLUSH (from DATA; from CMD after the handshake).
REQ-039 In FLUSH:
  - when the beat counter reaches MAP_WORDS/2, or the FIFO is empty after an overflow, done = 1 for one cycle;
  - the state then returns to IDLE.
REQ-040 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL span 0..FIFO_DEPTH.

Reset
REQ-041 On rst = 0, asynchronously:
  - state = IDLE;
  - all dma_write_* outputs = 0;
  - done = 0, overflow = 0, debug = 0;
  - FIFO empty, counters 0, half = 0, hold = 0.
REQ-042 Reset mid-operation SHALL discard buffered data with no further beats or done.

Verification
REQ-043 MAP_WORDS=4; start, map_sel=0; ctrl_ready after 2 cycles; results 1,2,3,4 with sel=1; chnl_ready=1 -> index 0, length 16, size 3; beats 0x0000_0002_0000_0001 and 0x0000_0004_0000_0003; done 1 cycle after the 2nd pop.
REQ-044 map_sel=1; results with sel=1 interleaved with sel=2 -> sel=1 ignored; index 0x4000; only sel=2 values are packed.
REQ-045 FIFO_DEPTH=2; chnl_ready=0 while 6 results arrive -> 3rd beat dropped, overflow=1; after ready=1, 2 beats drain, then done.
REQ-046 chnl_ready toggling every cycle -> data stable while stalled; beat order preserved; MAP_WORDS/2 pops total.
REQ-047 Results arriving in CMD before ctrl_ready -> buffered; emitted after the handshake; extra results after MAP_WORDS are discarded.
REQ-048 rst asserted in DATA with 3 beats queued -> outputs 0 immediately; a subsequent start runs a clean map.

Source files
------------

// File: rtl/conv_result_packer_dma64_if.sv
// Bus bundle between the result packer, the conv core result port and the
// DMA write engine. The packer takes the master side; the slave side is the
// environment (conv core results in, DMA command and data channels out).
interface conv_result_packer_dma64_if;
    logic        res_wr;
    logic [19:0] res_data;
    logic [2:0]  res_sel;

    logic        dma_write_ctrl_ready;
    logic        dma_write_ctrl_valid;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;

    logic        dma_write_chnl_ready;
    logic        dma_write_chnl_valid;
    logic [63:0] dma_write_chnl_data;

    modport master (
        input  res_wr,
        input  res_data,
        input  res_sel,
        input  dma_write_ctrl_ready,
        output dma_write_ctrl_valid,
        output dma_write_ctrl_data_index,
        output dma_write_ctrl_data_length,
        output dma_write_ctrl_data_size,
        input  dma_write_chnl_ready,
        output dma_write_chnl_valid,
        output dma_write_chnl_data
    );

    modport slave (
        output res_wr,
        output res_data,
        output res_sel,
        output dma_write_ctrl_ready,
        input  dma_write_ctrl_valid,
        input  dma_write_ctrl_data_index,
        input  dma_write_ctrl_data_length,
        input  dma_write_ctrl_data_size,
        output dma_write_chnl_ready,
        input  dma_write_chnl_valid,
        input  dma_write_chnl_data
    );
endinterface

// File: rtl/conv_result_packer_dma64.sv
// Conv result packer: collects 20-bit results for one feature map, packs
// them two per 64-bit beat and streams the beats to a DMA write engine after
// issuing one write command per map. A small FIFO absorbs DMA backpressure;
// since the conv core cannot be stalled, a beat that finds the FIFO full is
// dropped and flagged with a sticky overflow bit.
module conv_result_packer_dma64 #(
    parameter int unsigned MAP_WORDS  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MAP0_BASE  = 32'h0000_0000,
    parameter logic [31:0] MAP1_BASE  = 32'h0000_4000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              map_sel,
    conv_result_packer_dma64_if.master        bus,
    output logic                              done,
    output logic                              overflow,
    output logic [31:0]                       debug
);

    localparam int unsigned CNT_W = $clog2(MAP_WORDS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] MAP_WORDS_C = CNT_W'(MAP_WORDS);
    localparam logic [CNT_W-1:0] MAP_BEATS_C = CNT_W'(MAP_WORDS / 2);
    localparam logic [OCC_W-1:0] DEPTH_C     = OCC_W'(FIFO_DEPTH);
    localparam logic [31:0]      LENGTH_C    = 32'(MAP_WORDS * 4);
    localparam logic [2:0]       SIZE_C      = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mapSel_q, mapSel_d;

    logic              ctrlValid_q, ctrlValid_d;
    logic [31:0]       ctrlIndex_q, ctrlIndex_d;
    logic [31:0]       ctrlLength_q, ctrlLength_d;
    logic [2:0]        ctrlSize_q, ctrlSize_d;

    logic [CNT_W-1:0]  resCnt_q, resCnt_d;
    logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
    logic              half_q, half_d;
    logic [19:0]       hold_q, hold_d;

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [63:0]       fifoMem [FIFO_DEPTH];

    logic              overflow_q, overflow_d;
    logic [31:0]       debug_q, debug_d;
    logic              doneFlag;

    logic              fifoEmpty;
    logic              fifoFull;
    logic              chnlValid;
    logic              pop;
    logic              resAccept;
    logic              beatPush;
    logic              pushOk;
    logic              beatDrop;
    logic [63:0]       beatData;

    // Datapath qualifiers: FIFO status, result acceptance and beat push/pop.
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    always_comb begin
        fifoEmpty = (occ_q == '0);
        fifoFull  = (occ_q == DEPTH_C);
        chnlValid = !fifoEmpty && ((state_q == DATA) || (state_q == FLUSH));
        pop       = chnlValid && bus.dma_write_chnl_ready;
        resAccept = ((state_q == CMD) || (state_q == DATA))
                    && bus.res_wr
                    && (bus.res_sel == (3'd1 + {2'b00, mapSel_q}))
                    && (resCnt_q < MAP_WORDS_C);
        beatPush  = resAccept && half_q;
        pushOk    = beatPush && (!fifoFull || pop);
        beatDrop  = beatPush && fifoFull && !pop;
        beatData  = {12'd0, bus.res_data, 12'd0, hold_q};
    end

    // Next-state logic for the control FSM, counters, packing and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        mapSel_d     = mapSel_q;
        ctrlValid_d  = ctrlValid_q;
        ctrlIndex_d  = ctrlIndex_q;
        ctrlLength_d = ctrlLength_q;
        ctrlSize_d   = ctrlSize_q;
        resCnt_d     = resCnt_q;
        beatCnt_d    = beatCnt_q;
        half_d       = half_q;
        hold_d       = hold_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        occ_d        = occ_q;
        overflow_d   = overflow_q;
        doneFlag     = 1'b0;

        if (pop) begin
            rdPtr_d   = rdPtr_q + 1'b1;
            beatCnt_d = beatCnt_q + 1'b1;
        end

        if (resAccept) begin
            resCnt_d = resCnt_q + 1'b1;
            if (half_q) begin
                half_d = 1'b0;
            end else begin
                hold_d = bus.res_data;
                half_d = 1'b1;
            end
        end

        if (pushOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        if (beatDrop) begin
            overflow_d = 1'b1;
        end

        case ({pushOk, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    mapSel_d     = map_sel;
                    ctrlValid_d  = 1'b1;
                    ctrlIndex_d  = map_sel ? MAP1_BASE : MAP0_BASE;
                    ctrlLength_d = LENGTH_C;
                    ctrlSize_d   = SIZE_C;
                    resCnt_d     = '0;
                    beatCnt_d    = '0;
                    half_d       = 1'b0;
                    wrPtr_d      = '0;
                    rdPtr_d      = '0;
                    occ_d        = '0;
                    overflow_d   = 1'b0;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (bus.dma_write_ctrl_ready) begin
                    ctrlValid_d = 1'b0;
                    state_d     = (resCnt_q == MAP_WORDS_C) ? FLUSH : DATA;
                end
            end
            DATA: begin
                if (resCnt_q == MAP_WORDS_C) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((beatCnt_q == MAP_BEATS_C) || (fifoEmpty && overflow_q)) begin
                    doneFlag = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        debug_d = {27'd0, overflow_d, (occ_d == '0), 1'b0, state_d};
    end

    // State and control registers; reset clears everything, including the
    // debug snapshot, so all observable outputs read zero while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mapSel_q     <= 1'b0;
            ctrlValid_q  <= 1'b0;
            ctrlIndex_q  <= '0;
            ctrlLength_q <= '0;
            ctrlSize_q   <= '0;
            resCnt_q     <= '0;
            beatCnt_q    <= '0;
            half_q       <= 1'b0;
            hold_q       <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            occ_q        <= '0;
            overflow_q   <= 1'b0;
            debug_q      <= '0;
        end else begin
            state_q      <= state_d;
            mapSel_q     <= mapSel_d;
            ctrlValid_q  <= ctrlValid_d;
            ctrlIndex_q  <= ctrlIndex_d;
            ctrlLength_q <= ctrlLength_d;
            ctrlSize_q   <= ctrlSize_d;
            resCnt_q     <= resCnt_d;
            beatCnt_q    <= beatCnt_d;
            half_q       <= half_d;
            hold_q       <= hold_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            occ_q        <= occ_d;
            overflow_q   <= overflow_d;
            debug_q      <= debug_d;
        end
    end

    // Beat storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr_q] <= beatData;
        end
    end

    assign bus.dma_write_ctrl_valid       = ctrlValid_q;
    assign bus.dma_write_ctrl_data_index  = ctrlIndex_q;
    assign bus.dma_write_ctrl_data_length = ctrlLength_q;
    assign bus.dma_write_ctrl_data_size   = ctrlSize_q;
    assign bus.dma_write_chnl_valid       = chnlValid;
    assign bus.dma_write_chnl_data        = chnlValid ? fifoMem[rdPtr_q] : 64'd0;

    assign done     = doneFlag;
    assign overflow = overflow_q;
    assign debug    = debug_q;

endmodule

// File: tb/tb_conv_result_packer_dma64.sv
// Testbench for conv_result_packer_dma64: directed and randomized maps,
// checked cycle by cycle against a queue-based reference of the packer.
module tb_conv_result_packer_dma64;

    localparam int          MW    = 6;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        map_sel;
    logic        done;
    logic        overflow;
    logic [31:0] debug;

    conv_result_packer_dma64_if bus ();

    conv_result_packer_dma64 #(
        .MAP_WORDS  (MW),
        .FIFO_DEPTH (DEPTH),
        .MAP0_BASE  (BASE0),
        .MAP1_BASE  (BASE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .map_sel  (map_sel),
        .bus      (bus),
        .done     (done),
        .overflow (overflow),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model of the packer
    int          phase;
    bit          mSel;
    bit          mCtrlValid;
    logic [31:0] mIndex;
    int          rcnt;
    int          beats;
    bit          half;
    logic [19:0] hold;
    logic [63:0] q [$];
    bit          ovf;
    bit          freshReset;
    int          doneCount = 0;

    // what the DUT actually delivered
    logic [63:0] dutLog [$];
    int          dutDone = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit expValidF();
        return (q.size() > 0) && (phase >= 2);
    endfunction

    function automatic bit expDoneF();
        return (phase == 3) && ((beats == MW / 2) || ((q.size() == 0) && ovf));
    endfunction

    task automatic checkAll();
        logic [31:0] expDebug;
        checkOutput("chnl_valid", 64'(bus.dma_write_chnl_valid), 64'(expValidF()));
        if (expValidF()) checkOutput("chnl_data", bus.dma_write_chnl_data, q[0]);
        checkOutput("ctrl_valid", 64'(bus.dma_write_ctrl_valid), 64'(mCtrlValid));
        if (mCtrlValid) begin
            checkOutput("ctrl_index", 64'(bus.dma_write_ctrl_data_index), 64'(mIndex));
            checkOutput("ctrl_length", 64'(bus.dma_write_ctrl_data_length), 64'(MW * 4));
            checkOutput("ctrl_size", 64'(bus.dma_write_ctrl_data_size), 64'd3);
        end
        checkOutput("done", 64'(done), 64'(expDoneF()));
        checkOutput("overflow", 64'(overflow), 64'(ovf));
        expDebug = freshReset ? 32'd0 : {27'd0, ovf, (q.size() == 0), 1'b0, 2'(phase)};
        checkOutput("debug", 64'(debug), 64'(expDebug));
    endtask

    // advance the reference by one clock using the inputs now applied
    task automatic modelStep();
        bit          pop;
        bit          accept;
        bit          dn;
        int          rcntOld;
        logic [63:0] beat;
        pop        = expValidF() && bus.dma_write_chnl_ready;
        dn         = expDoneF();
        accept     = ((phase == 1) || (phase == 2)) && bus.res_wr
                     && (int'(bus.res_sel) == 1 + int'(mSel)) && (rcnt < MW);
        rcntOld    = rcnt;
        freshReset = 1'b0;
        if (dn) doneCount++;
        if (phase == 0) begin
            if (start) begin
                mSel       = map_sel;
                mCtrlValid = 1'b1;
                mIndex     = map_sel ? BASE1 : BASE0;
                rcnt       = 0;
                beats      = 0;
                half       = 1'b0;
                q.delete();
                ovf        = 1'b0;
                phase      = 1;
            end
            return;
        end
        if (pop) begin
            void'(q.pop_front());
            beats++;
        end
        if (accept) begin
            if (!half) begin
                hold = bus.res_data;
                half = 1'b1;
            end else begin
                beat = {12'd0, bus.res_data, 12'd0, hold};
                if (q.size() < DEPTH) q.push_back(beat);
                else ovf = 1'b1;
                half = 1'b0;
            end
            rcnt++;
        end
        case (phase)
            1: if (bus.dma_write_ctrl_ready) begin
                   mCtrlValid = 1'b0;
                   phase = (rcntOld == MW) ? 3 : 2;
               end
            2: if (rcntOld == MW) phase = 3;
            3: if (dn) phase = 0;
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input bit s, input bit ms, input bit wr, input logic [19:0] d,
                                 input logic [2:0] rs, input bit cr, input bit chr);
        start                    = s;
        map_sel                  = ms;
        bus.res_wr               = wr;
        bus.res_data             = d;
        bus.res_sel              = rs;
        bus.dma_write_ctrl_ready = cr;
        bus.dma_write_chnl_ready = chr;
        checkAll();
        if ((bus.dma_write_chnl_valid === 1'b1) && chr) dutLog.push_back(bus.dma_write_chnl_data);
        if (done === 1'b1) dutDone++;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("rst_ctrl_valid", 64'(bus.dma_write_ctrl_valid), 64'd0);
        checkOutput("rst_ctrl_index", 64'(bus.dma_write_ctrl_data_index), 64'd0);
        checkOutput("rst_ctrl_length", 64'(bus.dma_write_ctrl_data_length), 64'd0);
        checkOutput("rst_ctrl_size", 64'(bus.dma_write_ctrl_data_size), 64'd0);
        checkOutput("rst_chnl_valid", 64'(bus.dma_write_chnl_valid), 64'd0);
        checkOutput("rst_chnl_data", bus.dma_write_chnl_data, 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_debug", 64'(debug), 64'd0);
        phase = 0; mSel = 1'b0; mCtrlValid = 1'b0; mIndex = '0;
        rcnt = 0; beats = 0; half = 1'b0; hold = '0; q.delete(); ovf = 1'b0;
        freshReset = 1'b1;
        start = 1'b0; map_sel = 1'b0;
        bus.res_wr = 1'b0; bus.res_data = '0; bus.res_sel = '0;
        bus.dma_write_ctrl_ready = 1'b0; bus.dma_write_chnl_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // chnlMode: 0 always ready, 1 toggling, 2 held off until all results in, 3 random
    task automatic runMap(input bit sel, input int readyDelay, input int chnlMode, input int wrPct,
                          input int wrongPct, input bit seqData, output int pops, output int dones);
        int          n;
        int          logStart;
        int          doneStart;
        int          dutDoneStart;
        int          seq;
        bit          crdy;
        bit          wr;
        logic [2:0]  rs;
        logic [2:0]  good;
        logic [19:0] d;
        logStart     = dutLog.size();
        doneStart    = doneCount;
        dutDoneStart = dutDone;
        good         = 3'(1 + int'(sel));
        seq          = 1;
        applyStimulus(1'b1, sel, 1'b0, '0, '0, 1'b0, 1'b0);
        n = 0;
        while ((doneCount == doneStart) && (n < 500)) begin
            case (chnlMode)
                0:       crdy = 1'b1;
                1:       crdy = n[0];
                2:       crdy = (rcnt >= MW);
                default: crdy = 1'($urandom_range(0, 1));
            endcase
            wr = ($urandom_range(0, 99) < wrPct);
            rs = good;
            if ($urandom_range(0, 99) < wrongPct) begin
                rs = 3'($urandom_range(0, 7));
                if (rs == good) rs = rs + 3'd1;
            end
            d = 20'($urandom);
            if (seqData) begin
                d = 20'(seq);
                if (wr && rs == good) seq++;
            end
            applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), wr, d, rs,
                          (n >= readyDelay), crdy);
            n++;
        end
        checkOutput("map_timeout", 64'(n < 500), 64'd1);
        pops  = dutLog.size() - logStart;
        dones = dutDone - dutDoneStart;
    endtask

    initial begin
        int pops;
        int dones;
        int base;
        rst = 1'b1;
        #1;
        $display("[TB] reset check");
        doReset();

        $display("[TB] map 0, sequential data, ctrl_ready after 2 cycles");
        base = dutLog.size();
        runMap(1'b0, 2, 0, 100, 0, 1'b1, pops, dones);
        checkOutput("m0_pops", 64'(pops), 64'(MW / 2));
        checkOutput("m0_dones", 64'(dones), 64'd1);
        if (pops == MW / 2) begin
            checkOutput("m0_beat0", dutLog[base], 64'h0000_0002_0000_0001);
            checkOutput("m0_beat1", dutLog[base + 1], 64'h0000_0004_0000_0003);
            checkOutput("m0_beat2", dutLog[base + 2], 64'h0000_0006_0000_0005);
        end

        $display("[TB] map 1, interleaved wrong selects, random chnl ready");
        runMap(1'b1, 1, 3, 80, 50, 1'b0, pops, dones);
        checkOutput("m1_pops", 64'(pops), 64'(beats));
        checkOutput("m1_dones", 64'(dones), 64'd1);

        $display("[TB] overflow with chnl_ready held low");
        runMap(1'b0, 0, 2, 100, 0, 1'b0, pops, dones);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_pops", 64'(pops), 64'(DEPTH));
        checkOutput("ovf_dones", 64'(dones), 64'd1);

        $display("[TB] chnl_ready toggling");
        runMap(1'b1, 0, 1, 100, 20, 1'b0, pops, dones);
        checkOutput("tog_ovf_cleared", 64'(overflow), 64'd0);
        checkOutput("tog_pops", 64'(pops), 64'(MW / 2));

        $display("[TB] results buffered during CMD");
        runMap(1'b0, 4, 0, 100, 0, 1'b0, pops, dones);
        checkOutput("cmd_pops", 64'(pops), 64'(MW / 2));
        checkOutput("cmd_ovf", 64'(overflow), 64'd0);

        $display("[TB] reset with beats queued");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 20'($urandom), 3'd1, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 64'(bus.dma_write_chnl_valid), 64'd1);
        #2;
        base = dutDone;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("post_rst_no_done", 64'(dutDone - base), 64'd0);
        runMap(1'b0, 1, 0, 100, 0, 1'b1, pops, dones);
        checkOutput("clean_pops", 64'(pops), 64'(MW / 2));
        checkOutput("clean_dones", 64'(dones), 64'd1);

        $display("[TB] random maps");
        for (int i = 0; i < 8; i++) begin
            runMap(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom_range(50, 100), $urandom_range(0, 40), 1'b0, pops, dones);
            checkOutput("rand_pops", 64'(pops), 64'(beats));
            checkOutput("rand_dones", 64'(dones), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
